// File: rtl/alu_op_sequencer.sv
// Opcode sequencer for the 16-bit ALU datapath: operand-mux and function selects, latency timing, accumulator, response channel.
// Optional ALU_SEQ_FLAGS_EN adds zero/negative accumulator flags and a saturating busy-cycle counter.
module alu_op_sequencer #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 4,
  parameter int unsigned N       = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [1:0]   cmd_bsrc,
  output logic [1:0]   a_s,
  output logic [3:0]   b_s,
  output logic [8:0]   alu_sel,
  input  logic [N-1:0] b_operand,
  input  logic [N-1:0] alu_result,
  output logic [N-1:0] acc,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_err
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic         flag_z,
  output logic         flag_n,
  output logic [15:0]  busy_cycles
`endif
);

  localparam int unsigned LAT_W = 4;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_CLR = 4'hF;

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_e;

  state_e           state_q;
  logic [3:0]       op_q;
  logic [LAT_W-1:0] lat_cnt_q;
  logic             first_q;
  logic [N-1:0]     acc_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [N-1:0]     rsp_data_q;
  logic             rsp_err_q;
  logic [1:0]       a_s_q;
  logic [3:0]       b_s_q;
  logic [8:0]       alu_sel_q;

  function automatic logic [3:0] bsrc_onehot(input logic [1:0] src);
    case (src)
      2'd0:    return 4'b0100;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b1000;
      default: return 4'b0001;
    endcase
  endfunction

  // Only called for ops 1..9, whose select bit is op-1.
  function automatic logic [8:0] op_onehot(input logic [3:0] op);
    return 9'(1) << (op - 4'd1);
  endfunction

  function automatic logic [LAT_W-1:0] lat_of(input logic [3:0] op);
    case (op)
      4'h2:    return LAT_W'(MUL_LAT);
      4'h3:    return LAT_W'(DIV_LAT);
      default: return LAT_W'(1);
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

`ifdef ALU_SEQ_FLAGS_EN
  logic        flag_z_q;
  logic        flag_n_q;
  logic [15:0] busy_q;
`endif

  // Sequencer FSM; every output is a register set for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      lat_cnt_q   <= '0;
      first_q     <= 1'b0;
      acc_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      a_s_q       <= 2'b01;
      b_s_q       <= 4'b0001;
      alu_sel_q   <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      flag_z_q    <= 1'b1;
      flag_n_q    <= 1'b0;
`endif
    end else begin
      a_s_q     <= 2'b01;
      b_s_q     <= 4'b0001;
      alu_sel_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_op;
            cmd_ready_q <= 1'b0;
            if (is_illegal(cmd_op)) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '1;
            end else begin
              state_q <= LOAD;
              a_s_q   <= 2'b10;
              b_s_q   <= bsrc_onehot(cmd_bsrc);
            end
          end
        end
        LOAD: begin
          if (op_q == OP_NOP || op_q == OP_CLR) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            if (op_q == OP_CLR) begin
              acc_q      <= '0;
              rsp_data_q <= '0;
`ifdef ALU_SEQ_FLAGS_EN
              flag_z_q   <= 1'b1;
              flag_n_q   <= 1'b0;
`endif
            end else begin
              rsp_data_q <= acc_q;
            end
          end else begin
            state_q   <= EXEC;
            alu_sel_q <= op_onehot(op_q);
            lat_cnt_q <= lat_of(op_q);
            first_q   <= 1'b1;
          end
        end
        EXEC: begin
          first_q   <= 1'b0;
          lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          // Divide-by-zero check takes priority even when DIV_LAT is 1.
          if (first_q && op_q == OP_DIV && b_operand == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '1;
          end else if (lat_cnt_q == LAT_W'(1)) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= alu_result;
            acc_q       <= alu_result;
`ifdef ALU_SEQ_FLAGS_EN
            flag_z_q    <= (alu_result == '0);
            flag_n_q    <= alu_result[N-1];
`endif
          end else begin
            alu_sel_q <= alu_sel_q;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Saturating count of cycles spent outside IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else if (state_q != IDLE && busy_q != 16'hFFFF) begin
      busy_q <= busy_q + 16'd1;
    end
  end

  assign flag_z      = flag_z_q;
  assign flag_n      = flag_n_q;
  assign busy_cycles = busy_q;
`endif

  assign cmd_ready = cmd_ready_q;
  assign a_s       = a_s_q;
  assign b_s       = b_s_q;
  assign alu_sel   = alu_sel_q;
  assign acc       = acc_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
